pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL provide parameter LIVES, default 3, meaning lives loaded at game start (range 1..7).
REQ-002 SHALL provide parameter SERVE_FRAMES, default 60, meaning frame ticks spent in SERVE before play.
REQ-003 SHALL provide parameter MISS_FRAMES, default 30, meaning frame ticks spent in MISS (flash period).
REQ-004 SHALL provide port CLK_100MHz  input  1  sole clock; all state on rising edge.
REQ-005 SHALL provide port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port frameTick  input  1  one-cycle pulse from clock divider, widget motion rate.
REQ-007 SHALL provide port serveBtn  input  1  raw asynchronous serve/start button, active-high.
REQ-008 SHALL provide port hitPulse  input  1  one-cycle pulse, ball struck paddle.
REQ-009 SHALL provide port missPulse  input  1  one-cycle pulse, ball passed paddle edge.
REQ-010 SHALL provide port widgetEn  output  1  gated frameTick driving ball and paddle widget enable.
REQ-011 SHALL provide port ballLoad  output  1  one-cycle pulse; ball widget reloads firstX/firstY.
REQ-012 SHALL provide port score  output  8  two-digit BCD score, [7:4] tens, [3:0] units.
REQ-013 SHALL provide port lives  output  3  remaining lives, binary.
REQ-014 SHALL provide port flash  output  1  high during MISS on alternate 8-frame phases, for border colour.
REQ-015 SHALL provide port state  output  3  encoded FSM state: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.

Function
REQ-016 SHALL pass serveBtn through a 2-flop synchronizer, then a rising-edge detector producing one-cycle servePress.
REQ-017 SHALL hold a frame counter (8 bits) that clears on every state entry and increments only on frameTick.
REQ-018 SHALL, in IDLE, drive widgetEn=0; on servePress load lives=LIVES, score=0x00, pulse ballLoad, go to SERVE.
REQ-019 SHALL, in SERVE, drive widgetEn=0; when counter reaches SERVE_FRAMES-1 and frameTick asserts, go to PLAY.
REQ-020 SHALL, in PLAY, drive widgetEn=frameTick combinationally (zero added latency).
REQ-021 SHALL, in PLAY on hitPulse, increment score in BCD: units 9 wraps to 0 with tens carry; 0x99 saturates at 0x99.
REQ-022 SHALL, in PLAY on missPulse, decrement lives and go to MISS; hitPulse and missPulse in the same cycle: miss wins, score unchanged.
REQ-023 SHALL, in MISS, drive widgetEn=0 and flash=counter[3]; after MISS_FRAMES ticks go to SERVE with ballLoad pulse if lives!=0, else to OVER.
REQ-024 SHALL, in OVER, drive widgetEn=0, flash=0, hold score; on servePress go to IDLE.
REQ-025 SHALL ignore hitPulse/missPulse outside PLAY and servePress outside IDLE/OVER.
REQ-026 SHALL register ballLoad, score, lives, flash, state; ballLoad asserts the cycle after the causing event, exactly one cycle wide.
REQ-027 SHALL treat unused state encodings 5..7 as IDLE on the next clock.

Reset
REQ-028 SHALL, while Reset=0, asynchronously force state=IDLE, score=0x00, lives=0, counter=0, ballLoad=0, flash=0, synchronizer flops=0; widgetEn=0 follows.
REQ-029 SHALL resume from IDLE on the first clock after Reset deasserts, regardless of state when Reset asserted, including mid-MISS or mid-SERVE.

Verification
REQ-030 SHALL cover: Reset low, serveBtn 0->1 held 5 cycles -> one ballLoad pulse, lives=3, score=0x00, state=SERVE; after 60 frameTicks state=PLAY.
REQ-031 SHALL cover: in PLAY, 10 hitPulses from score 0x09 -> score 0x19; from 0x98 two hits -> 0x99, then third hit stays 0x99.
REQ-032 SHALL cover: PLAY, hitPulse and missPulse same cycle with lives=3 -> lives=2, score unchanged, state=MISS, flash toggles every 8 frameTicks.
REQ-033 SHALL cover: lives=1, missPulse, 30 frameTicks -> state=OVER, no ballLoad, widgetEn=0; servePress -> IDLE.
REQ-034 SHALL cover: Reset asserted mid-SERVE at counter=25 -> all outputs at reset values same cycle, IDLE after release.
REQ-035 SHALL cover: frameTick pulses in SERVE/MISS/OVER -> widgetEn never asserts; in PLAY widgetEn equals frameTick cycle-for-cycle.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/miss/game-over sequencing, BCD score and
// lives bookkeeping, and gating of the widget motion enable.
module pong_game_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic       frameTick,
  input  logic       serveBtn,
  input  logic       hitPulse,
  input  logic       missPulse,
  output logic       widgetEn,
  output logic       ballLoad,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       flash,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MissLast  = 8'(MISS_FRAMES - 1);
  localparam logic [2:0] LivesInit = 3'(LIVES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] score_q, score_d;
  logic [2:0] lives_q, lives_d;
  logic       ball_load_q, ball_load_d;
  logic       flash_q, flash_d;
  logic       sync1_q, sync2_q, btn_prev_q;
  logic       serve_press;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // Button synchronizer and rising-edge history.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      sync1_q    <= serveBtn;
      sync2_q    <= sync1_q;
      btn_prev_q <= sync2_q;
    end
  end

  assign serve_press = sync2_q & ~btn_prev_q;

  // Next-state, score/lives update, frame counter and registered output values.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    ball_load_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (serve_press) begin
          lives_d     = LivesInit;
          score_d     = 8'h00;
          ball_load_d = 1'b1;
          state_d     = StServe;
        end
      end
      StServe: begin
        if (frameTick && (cnt_q == ServeLast)) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // A simultaneous miss takes priority and leaves the score untouched.
        if (missPulse) begin
          lives_d = lives_q - 3'd1;
          state_d = StMiss;
        end else if (hitPulse) begin
          score_d = bcd_inc(score_q);
        end
      end
      StMiss: begin
        if (frameTick && (cnt_q == MissLast)) begin
          if (lives_q != 3'd0) begin
            state_d     = StServe;
            ball_load_d = 1'b1;
          end else begin
            state_d = StOver;
          end
        end
      end
      StOver: begin
        if (serve_press) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counter restarts on every state change, otherwise counts frame ticks.
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (frameTick) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    flash_d = (state_d == StMiss) & cnt_d[3];
  end

  // State and registered outputs.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      score_q     <= 8'h00;
      lives_q     <= 3'd0;
      ball_load_q <= 1'b0;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      ball_load_q <= ball_load_d;
      flash_q     <= flash_d;
    end
  end

  // Motion enable passes the frame tick straight through only while playing.
  always_comb begin
    widgetEn = (state_q == StPlay) & frameTick;
  end

  assign ballLoad = ball_load_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign flash    = flash_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus a random soak, all
// checked cycle by cycle against a game-rule reference model.
module tb_pong_game_ctrl;

  localparam int NLives = 3;
  localparam int SFrames = 60;
  localparam int MFrames = 30;

  localparam int MIdle = 0;
  localparam int MServe = 1;
  localparam int MPlay = 2;
  localparam int MMiss = 3;
  localparam int MOver = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       widget_en;
  logic       ball_load;
  logic [7:0] score_o;
  logic [2:0] lives_o;
  logic       flash_o;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;
  int ball_cnt = 0;

  // Reference model: game state, ticks since entering it, score as a plain number.
  int m_state;
  int m_frames;
  int m_score;
  int m_lives;
  bit m_ball;
  bit btn_hist[$];

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .LIVES(NLives),
    .SERVE_FRAMES(SFrames),
    .MISS_FRAMES(MFrames)
  ) dut (
    .CLK_100MHz(clk),
    .Reset(rst_n),
    .frameTick(tick),
    .serveBtn(btn),
    .hitPulse(hit),
    .missPulse(miss),
    .widgetEn(widget_en),
    .ballLoad(ball_load),
    .score(score_o),
    .lives(lives_o),
    .flash(flash_o),
    .state(state_o)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = 32'(((v / 10) << 4) | (v % 10));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_frames = 0;
    m_score = 0;
    m_lives = 0;
    m_ball = 1'b0;
    btn_hist.delete();
  endtask

  task automatic enter(input int s);
    m_state = s;
    m_frames = 0;
  endtask

  // One clock of game rules; the button is seen two clocks late through the synchronizer.
  task automatic model_step(input bit t, input bit h, input bit m, input bit b);
    int n;
    bit press;
    n = btn_hist.size();
    press = (n >= 2 && btn_hist[n-2]) && !(n >= 3 && btn_hist[n-3]);
    m_ball = 1'b0;
    case (m_state)
      MIdle: if (press) begin
        m_lives = NLives;
        m_score = 0;
        m_ball = 1'b1;
        enter(MServe);
      end
      MServe: if (t) begin
        m_frames++;
        if (m_frames == SFrames) enter(MPlay);
      end
      MPlay: begin
        if (m) begin
          m_lives--;
          enter(MMiss);
        end else begin
          if (h && m_score < 99) m_score++;
          if (t) m_frames++;
        end
      end
      MMiss: if (t) begin
        m_frames++;
        if (m_frames == MFrames) begin
          if (m_lives > 0) begin
            enter(MServe);
            m_ball = 1'b1;
          end else begin
            enter(MOver);
          end
        end
      end
      MOver: if (press) enter(MIdle);
      default: enter(MIdle);
    endcase
    btn_hist.push_back(b);
    if (btn_hist.size() > 4) void'(btn_hist.pop_front());
  endtask

  task automatic check_outputs();
    bit exp_flash;
    exp_flash = (m_state == MMiss) && (((m_frames / 8) % 2) == 1);
    chk("state", 32'(state_o), 32'(m_state));
    chk("score", 32'(score_o), to_bcd(m_score));
    chk("lives", 32'(lives_o), 32'(m_lives));
    chk("ballLoad", 32'(ball_load), 32'(m_ball));
    chk("flash", 32'(flash_o), 32'(exp_flash));
  endtask

  // Apply inputs just after an edge, check the combinational enable, clock, check registers.
  task automatic cycle(input bit t, input bit h, input bit m, input bit b);
    tick = t;
    hit = h;
    miss = m;
    btn = b;
    #1;
    chk("widgetEn", 32'(widget_en), 32'((m_state == MPlay) && t));
    @(posedge clk);
    model_step(t, h, m, b);
    #1;
    if (ball_load) ball_cnt++;
    check_outputs();
  endtask

  // Deliver n frame ticks with random gaps; stray hit/miss pulses ride along.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press();
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_state", 32'(state_o), 32'(0));
    chk("rst_score", 32'(score_o), 32'h00);
    chk("rst_lives", 32'(lives_o), 32'(0));
    chk("rst_ballLoad", 32'(ball_load), 32'(0));
    chk("rst_flash", 32'(flash_o), 32'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start: one ballLoad, full lives, zero score, then 60 ticks of serve.
    ball_cnt = 0;
    press();
    chk("start_ball_cnt", 32'(ball_cnt), 32'(1));
    chk("start_state", 32'(state_o), 32'(MServe));
    chk("start_lives", 32'(lives_o), 32'(3));
    ticks(59);
    chk("serve59_state", 32'(state_o), 32'(MServe));
    ticks(1);
    chk("serve60_state", 32'(state_o), 32'(MPlay));

    // BCD counting and saturation.
    hits(9);
    chk("score_09", 32'(score_o), 32'h09);
    hits(10);
    chk("score_19", 32'(score_o), 32'h19);
    hits(79);
    chk("score_98", 32'(score_o), 32'h98);
    hits(2);
    chk("score_99", 32'(score_o), 32'h99);
    hits(1);
    chk("score_sat", 32'(score_o), 32'h99);

    // Hit and miss together: miss wins.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("hm_lives", 32'(lives_o), 32'(2));
    chk("hm_score", 32'(score_o), 32'h99);
    chk("hm_state", 32'(state_o), 32'(MMiss));
    ticks(8);
    chk("flash_on", 32'(flash_o), 32'(1));
    ticks(8);
    chk("flash_off", 32'(flash_o), 32'(0));
    ticks(14);
    chk("miss_to_serve", 32'(state_o), 32'(MServe));

    // Burn the remaining lives down to game over.
    ticks(60);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("lives_1", 32'(lives_o), 32'(1));
    ticks(30);
    ticks(60);
    hits(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lives_0", 32'(lives_o), 32'(0));
    ball_cnt = 0;
    ticks(30);
    chk("over_state", 32'(state_o), 32'(MOver));
    chk("over_no_ball", 32'(ball_cnt), 32'(0));
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("over_score_hold", 32'(score_o), 32'h99);
    press();
    chk("over_to_idle", 32'(state_o), 32'(MIdle));

    // Asynchronous reset in the middle of a serve.
    press();
    ticks(25);
    #1;
    tick = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state_o), 32'(0));
    chk("midrst_score", 32'(score_o), 32'h00);
    chk("midrst_lives", 32'(lives_o), 32'(0));
    chk("midrst_ballLoad", 32'(ball_load), 32'(0));
    chk("midrst_flash", 32'(flash_o), 32'(0));
    chk("midrst_widgetEn", 32'(widget_en), 32'(0));
    model_reset();
    tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_idle", 32'(state_o), 32'(MIdle));

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) btn = ~btn;
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 39) == 0), btn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
